axil_cfg_arbiter: RTL and testbench

Two-requester AXI4-Lite master arbiter and sequencer. It accepts single register read/write commands from two local requesters and grants them round-robin. Each granted command runs as exactly one AXI4-Lite transaction on a shared master port, and the result is returned to the requester that issued it. The block sits between the on-chip configuration clients and the M00_AXI master interface that drives the slave register space. Only one transaction is outstanding at a time.

---
 rtl/axil_cfg_arbiter.sv | 172 +++++++++++++++++
 tb/tb_axil_cfg_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/axil_cfg_arbiter.sv
// Round-robin arbiter for two register requesters sharing one AXI4-Lite master port.
// One transaction is outstanding at a time; the result returns to the requester that issued it.
module axil_cfg_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [1:0]            REQ_VALID,
  input  logic [1:0]            REQ_WE,
  input  logic [2*ADDR_W-1:0]   REQ_ADDR,
  input  logic [2*DATA_W-1:0]   REQ_WDATA,
  output logic [1:0]            REQ_READY,
  output logic [1:0]            RSP_VALID,
  output logic [DATA_W-1:0]     RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  BUSY,
  output logic [7:0]            ERR_CNT,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_RESP, DONE} state_t;

  state_t              state_reg, state_next;
  logic                last_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                aw_done_reg, aw_done_next;
  logic                w_done_reg, w_done_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                err_reg, err_next;
  logic [7:0]          err_cnt_reg;

  logic                win_idx;
  logic                accept;
  logic                aw_hs, w_hs;
  logic                resp_unused;
  logic [ADDR_W-1:0]   req_addr  [2];
  logic [DATA_W-1:0]   req_wdata [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign req_addr[gi]  = REQ_ADDR[gi*ADDR_W +: ADDR_W];
      assign req_wdata[gi] = REQ_WDATA[gi*DATA_W +: DATA_W];
      // Reset is folded in so READY drops the instant ARESETN falls.
      assign REQ_READY[gi] = ARESETN && accept && (win_idx == 1'(gi));
      assign RSP_VALID[gi] = (state_reg == DONE) && (last_reg == 1'(gi));
    end
  endgenerate

  // Only RESP[1] (SLVERR/DECERR) matters for error reporting.
  assign resp_unused = ^{M_AXI_BRESP[0], M_AXI_RRESP[0]};

  always_comb begin
    win_idx = 1'b0;
    case (REQ_VALID)
      2'b01:   win_idx = 1'b0;
      2'b10:   win_idx = 1'b1;
      2'b11:   win_idx = ~last_reg;
      default: win_idx = 1'b0;
    endcase
  end

  assign accept = (state_reg == IDLE) && (|REQ_VALID);

  assign M_AXI_AWADDR  = addr_reg;
  assign M_AXI_ARADDR  = addr_reg;
  assign M_AXI_WDATA   = wdata_reg;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = (state_reg == WR) && !aw_done_reg;
  assign M_AXI_WVALID  = (state_reg == WR) && !w_done_reg;
  assign M_AXI_BREADY  = (state_reg == WR_RESP);
  assign M_AXI_ARVALID = (state_reg == RD_ADDR);
  assign M_AXI_RREADY  = (state_reg == RD_RESP);
  assign aw_hs         = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs          = M_AXI_WVALID && M_AXI_WREADY;

  assign BUSY      = (state_reg != IDLE);
  assign RSP_RDATA = (state_reg == DONE) ? rdata_reg : '0;
  assign RSP_ERR   = (state_reg == DONE) && err_reg;
  assign ERR_CNT   = err_cnt_reg;

  always_comb begin
    state_next   = state_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    rdata_next   = rdata_reg;
    err_next     = err_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next   = REQ_WE[win_idx] ? WR : RD_ADDR;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end
      end
      WR: begin
        if (aw_hs) aw_done_next = 1'b1;
        if (w_hs)  w_done_next  = 1'b1;
        if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) state_next = WR_RESP;
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          state_next = DONE;
          rdata_next = '0;
          err_next   = M_AXI_BRESP[1];
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) state_next = RD_RESP;
      end
      RD_RESP: begin
        if (M_AXI_RVALID) begin
          state_next = DONE;
          rdata_next = M_AXI_RDATA;
          err_next   = M_AXI_RRESP[1];
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // last_reg doubles as the grant index of the transaction in flight.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg   <= IDLE;
      last_reg    <= 1'b1;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
      err_cnt_reg <= 8'd0;
    end else begin
      state_reg   <= state_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
      if (accept) begin
        last_reg  <= win_idx;
        addr_reg  <= req_addr[win_idx];
        wdata_reg <= req_wdata[win_idx];
      end
      if ((state_reg == DONE) && err_reg && (err_cnt_reg != 8'hFF))
        err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

endmodule

// File: tb/tb_axil_cfg_arbiter.sv
// Directed bench for axil_cfg_arbiter: a bench-driven AXI4-Lite slave and hand-computed
// expectations for latency, round-robin order, handshake ordering, error counting and reset.
module tb_axil_cfg_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] rsp_rdata;
  logic        rsp_err, busy;
  logic [7:0]  err_cnt;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_cfg_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .REQ_VALID(req_valid), .REQ_WE(req_we), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .REQ_READY(req_ready), .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .BUSY(busy), .ERR_CNT(err_cnt),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic slave_all_ready(input logic [31:0] data, input logic [1:0] resp);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = resp;
    arready = 1'b1; rvalid = 1'b1; rdata = data; rresp = resp;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; req_we = 2'b00; req_addr = '0; req_wdata = '0;
    slave_all_ready(32'h0, 2'b00);
    step();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b exp 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got %b exp 00", rsp_valid); end
    checks++; if ({busy, rsp_err} !== 2'b00) begin errors++; $display("FAIL rst_busy_err got %b exp 00", {busy, rsp_err}); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err_cnt got %0d exp 0", err_cnt); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rsp_rdata got %h exp 0", rsp_rdata); end
    checks++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin errors++; $display("FAIL rst_axi_valids got %b exp 00000", {awvalid, wvalid, bready, arvalid, rready}); end
    req_valid = 2'b00;
    #1 rst_n = 1'b1;
    step();
    $display("txn reset done");
  endtask

  task automatic test_single_write();
    slave_all_ready(32'h0, 2'b00);
    req_valid = 2'b01; req_we = 2'b01; req_addr = {32'h0, 32'h10}; req_wdata = {32'h0, 32'hDEADBEEF};
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_req_ready got %b exp 01", req_ready); end
    step();
    checks++; if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL wr_c1_valids got %b exp 11", {awvalid, wvalid}); end
    checks++; if (wstrb !== 4'hF) begin errors++; $display("FAIL wr_wstrb got %h exp f", wstrb); end
    checks++; if (awaddr !== 32'h10) begin errors++; $display("FAIL wr_awaddr got %h exp 10", awaddr); end
    checks++; if (wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wdata got %h exp deadbeef", wdata); end
    checks++; if (awprot !== 3'd0) begin errors++; $display("FAIL wr_awprot got %h exp 0", awprot); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_c1_busy got %b exp 1", busy); end
    req_valid = 2'b00;
    step();
    checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL wr_c2_b got %b exp 001", {awvalid, wvalid, bready}); end
    step();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL wr_c3_rsp_valid got %b exp 01", rsp_valid); end
    checks++; if ({rsp_err, busy} !== 2'b01) begin errors++; $display("FAIL wr_c3_err_busy got %b exp 01", {rsp_err, busy}); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL wr_c3_rdata got %h exp 0", rsp_rdata); end
    step();
    checks++; if ({rsp_valid, busy} !== 3'b000) begin errors++; $display("FAIL wr_c4_idle got %b exp 000", {rsp_valid, busy}); end
    $display("txn write req0 addr 10 data deadbeef");
  endtask

  task automatic test_single_read();
    slave_all_ready(32'h12345678, 2'b00);
    req_valid = 2'b10; req_we = 2'b00; req_addr = {32'h14, 32'h0};
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rd_req_ready got %b exp 10", req_ready); end
    step();
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL rd_c1_arvalid got %b exp 1", arvalid); end
    checks++; if (araddr !== 32'h14) begin errors++; $display("FAIL rd_araddr got %h exp 14", araddr); end
    checks++; if (arprot !== 3'd0) begin errors++; $display("FAIL rd_arprot got %h exp 0", arprot); end
    req_valid = 2'b00;
    step();
    checks++; if ({arvalid, rready} !== 2'b01) begin errors++; $display("FAIL rd_c2_r got %b exp 01", {arvalid, rready}); end
    step();
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rd_c3_rsp_valid got %b exp 10", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_c3_rdata got %h exp 12345678", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rd_c3_err got %b exp 0", rsp_err); end
    step();
    $display("txn read req1 addr 14 data %h", 32'h12345678);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    pulse_reset();
    slave_all_ready(32'hCAFE0001, 2'b00);
    req_valid = 2'b11; req_we = 2'b01; req_addr = {32'h44, 32'h40}; req_wdata = {32'h0, 32'h55};
    #1;
    for (int t = 0; t < 4; t++) begin
      exp = (t % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (req_ready !== exp) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", t, req_ready, exp); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy%0d got %b exp 0", t, busy); end
      step(); step(); step();
      checks++; if (rsp_valid !== exp) begin errors++; $display("FAIL rr_rsp%0d got %b exp %b", t, rsp_valid, exp); end
      checks++; if (rsp_rdata !== ((t % 2 == 0) ? 32'h0 : 32'hCAFE0001)) begin errors++; $display("FAIL rr_rdata%0d got %h", t, rsp_rdata); end
      step();
      $display("txn round-robin %0d granted %b", t, exp);
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_delayed_write();
    slave_all_ready(32'h0, 2'b00);
    awready = 1'b0; wready = 1'b0;
    req_valid = 2'b01; req_we = 2'b01; req_addr = {32'h0, 32'h20}; req_wdata = {32'h0, 32'hA5A55A5A};
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL dw_req_ready got %b exp 01", req_ready); end
    step();
    checks++; if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL dw_c1 got %b exp 11", {awvalid, wvalid}); end
    wready = 1'b1; req_valid = 2'b00;
    step();
    checks++; if ({awvalid, wvalid} !== 2'b10) begin errors++; $display("FAIL dw_c2 got %b exp 10", {awvalid, wvalid}); end
    wready = 1'b0;
    step();
    checks++; if ({awvalid, wvalid, bready} !== 3'b100) begin errors++; $display("FAIL dw_c3 got %b exp 100", {awvalid, wvalid, bready}); end
    checks++; if (awaddr !== 32'h20) begin errors++; $display("FAIL dw_awaddr got %h exp 20", awaddr); end
    awready = 1'b1;
    step();
    checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL dw_c4 got %b exp 001", {awvalid, wvalid, bready}); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL dw_c4_rsp got %b exp 00", rsp_valid); end
    awready = 1'b0;
    step();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL dw_c5_rsp got %b exp 01", rsp_valid); end
    step();
    checks++; if ({rsp_valid, bready, busy} !== 4'b0000) begin errors++; $display("FAIL dw_c6_idle got %b exp 0000", {rsp_valid, bready, busy}); end
    $display("txn delayed write req0 addr 20");
  endtask

  task automatic test_error_saturation();
    int exp_cnt;
    pulse_reset();
    slave_all_ready(32'h0BAD0BAD, 2'b10);
    req_we = 2'b00; req_addr = {32'h0, 32'h80};
    for (int k = 0; k < 300; k++) begin
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      step(); step();
      checks++; if ({rsp_valid, rsp_err} !== 3'b011) begin errors++; $display("FAIL err_rsp%0d got %b exp 011", k, {rsp_valid, rsp_err}); end
      step();
      exp_cnt = (k + 1 > 255) ? 255 : k + 1;
      checks++; if (err_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL err_cnt%0d got %0d exp %0d", k, err_cnt, exp_cnt); end
      $display("txn slverr read %0d err_cnt %0d", k, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    slave_all_ready(32'h0, 2'b00);
    bvalid = 1'b0;
    req_valid = 2'b01; req_we = 2'b01; req_addr = {32'h0, 32'h30}; req_wdata = {32'h0, 32'h1};
    step();
    req_valid = 2'b00;
    step();
    checks++; if ({bready, busy} !== 2'b11) begin errors++; $display("FAIL rm_wr_resp got %b exp 11", {bready, busy}); end
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    checks++; if ({bready, busy} !== 2'b00) begin errors++; $display("FAIL rm_async got %b exp 00", {bready, busy}); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rm_req_ready got %b exp 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_rsp_valid got %b exp 00", rsp_valid); end
    #1 rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_first_tie got %b exp 01", req_ready); end
    bvalid = 1'b1;
    step();
    req_valid = 2'b00;
    checks++; if ({awvalid, busy} !== 2'b11) begin errors++; $display("FAIL rm_restart got %b exp 11", {awvalid, busy}); end
    step(); step();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rm_rsp got %b exp 01", rsp_valid); end
    step();
    $display("txn reset mid-write, restart grant req0");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_delayed_write();
    test_error_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
